// File: rtl/lru_pkg.sv
// Shared sizing helpers, reset age encoding and a lowest-set-bit finder for the true-LRU replacer.
package lru_pkg;

   localparam int MAX_ASSOC = 16;
   localparam int MAX_AGE_W = 64;

   function automatic int way_bits(input int assoc);
      return $clog2(assoc);
   endfunction

   function automatic int age_vec_width(input int assoc);
      return assoc * $clog2(assoc);
   endfunction

   function automatic int valid_vec_width(input int assoc);
      return assoc;
   endfunction

   // Way w starts with age w, so way 0 is LRU out of reset.
   function automatic logic [MAX_AGE_W-1:0] reset_ages(input int assoc);
      logic [MAX_AGE_W-1:0] r;
      r = '0;
      for (int w = 0; w < assoc; w++) begin
         r = r | (MAX_AGE_W'(w) << (w * $clog2(assoc)));
      end
      return r;
   endfunction

   function automatic logic [3:0] lowest_set(input logic [MAX_ASSOC-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = MAX_ASSOC - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/lru_replacer_if.sv
// Request/response bundle between the cache miss FSM (master) and the LRU replacer (slave).
// Optional lock ports exist only when LRU_WAY_LOCK_EN is defined.
interface lru_replacer_if
   import lru_pkg::*;
#(
   parameter int NUM_SETS = 128,
   parameter int ASSOC    = 4
);
   localparam int INDEX_BITS = $clog2(NUM_SETS);
   localparam int WAY_BITS   = way_bits(ASSOC);

   logic                  touch_valid;
   logic [INDEX_BITS-1:0] touch_index;
   logic [WAY_BITS-1:0]   touch_way;
   logic                  touch_fill;
   logic                  inv_valid;
   logic [INDEX_BITS-1:0] inv_index;
   logic [WAY_BITS-1:0]   inv_way;
   logic                  victim_req;
   logic [INDEX_BITS-1:0] victim_index;
   logic                  victim_valid;
   logic [WAY_BITS-1:0]   victim_way;
   logic                  victim_was_invalid;
`ifdef LRU_WAY_LOCK_EN
   logic [ASSOC-1:0]      lock_mask;
   logic                  victim_none;
`endif

   modport master (
`ifdef LRU_WAY_LOCK_EN
      output lock_mask,
      input  victim_none,
`endif
      output touch_valid, touch_index, touch_way, touch_fill,
      output inv_valid, inv_index, inv_way,
      output victim_req, victim_index,
      input  victim_valid, victim_way, victim_was_invalid
   );

   modport slave (
`ifdef LRU_WAY_LOCK_EN
      input  lock_mask,
      output victim_none,
`endif
      input  touch_valid, touch_index, touch_way, touch_fill,
      input  inv_valid, inv_index, inv_way,
      input  victim_req, victim_index,
      output victim_valid, victim_way, victim_was_invalid
   );

endinterface

// File: rtl/lru_set_update.sv
// Combinational next-state of one set's age permutation and valid bits.
// An invalidate takes priority; a simultaneous touch is ignored.
module lru_set_update
   import lru_pkg::*;
#(
   parameter  int ASSOC    = 4,
   localparam int WAY_BITS = way_bits(ASSOC),
   localparam int AGE_W    = age_vec_width(ASSOC),
   localparam int VLD_W    = valid_vec_width(ASSOC)
) (
   input  logic [AGE_W-1:0]    age_i,
   input  logic [VLD_W-1:0]    valid_i,
   input  logic                touch_en_i,
   input  logic [WAY_BITS-1:0] touch_way_i,
   input  logic                touch_fill_i,
   input  logic                inv_en_i,
   input  logic [WAY_BITS-1:0] inv_way_i,
   output logic [AGE_W-1:0]    age_o,
   output logic [VLD_W-1:0]    valid_o
);
   localparam logic [WAY_BITS-1:0] ONE     = WAY_BITS'(1);
   localparam logic [WAY_BITS-1:0] AGE_MRU = WAY_BITS'(ASSOC - 1);

   logic [WAY_BITS-1:0] t_old_age;
   logic [WAY_BITS-1:0] i_old_age;

   assign t_old_age = age_i[int'(touch_way_i) * WAY_BITS +: WAY_BITS];
   assign i_old_age = age_i[int'(inv_way_i) * WAY_BITS +: WAY_BITS];

   for (genvar gi = 0; gi < ASSOC; gi++) begin : g_way
      localparam logic [WAY_BITS-1:0] WAY_ID = WAY_BITS'(gi);
      logic [WAY_BITS-1:0] age_w;
      logic [WAY_BITS-1:0] age_nx;
      logic                vld_nx;

      assign age_w = age_i[gi*WAY_BITS +: WAY_BITS];

      always_comb begin
         age_nx = age_w;
         vld_nx = valid_i[gi];
         if (inv_en_i) begin
            if (inv_way_i == WAY_ID) begin
               age_nx = '0;
               vld_nx = 1'b0;
            end else if (age_w < i_old_age) begin
               age_nx = age_w + ONE;
            end
         end else if (touch_en_i) begin
            if (touch_way_i == WAY_ID) begin
               age_nx = AGE_MRU;
               if (touch_fill_i) vld_nx = 1'b1;
            end else if (age_w > t_old_age) begin
               age_nx = age_w - ONE;
            end
         end
      end

      assign age_o[gi*WAY_BITS +: WAY_BITS] = age_nx;
      assign valid_o[gi]                    = vld_nx;
   end

endmodule

// File: rtl/lru_replacer.sv
// True-LRU replacement engine: per-set age permutation + valid bits, registered victim lookup.
// Define LRU_WAY_LOCK_EN to add lock_mask / victim_none.
module lru_replacer
   import lru_pkg::*;
#(
   parameter int NUM_SETS = 128,
   parameter int ASSOC    = 4
) (
   input  logic         clk,
   input  logic         reset,
   lru_replacer_if.slave bus
);
   localparam int WAY_BITS = way_bits(ASSOC);
   localparam int AGE_W    = age_vec_width(ASSOC);
   localparam int VLD_W    = valid_vec_width(ASSOC);
   localparam logic [AGE_W-1:0] AGE_RST = AGE_W'(reset_ages(ASSOC));

   // Flop arrays rather than RAM: every set must clear in one reset cycle.
   logic [AGE_W-1:0] age_q   [NUM_SETS];
   logic [VLD_W-1:0] valid_q [NUM_SETS];

   logic [AGE_W-1:0]    t_age_d, i_age_d, fwd_age;
   logic [VLD_W-1:0]    t_valid_d, i_valid_d, fwd_valid;
   logic [VLD_W-1:0]    lock_mask_w, unlocked, inv_cand;
   logic [WAY_BITS-1:0] sel_way_d, best_age;
   logic                sel_inv_d, found, touch_wr;
   logic                victim_valid_q, victim_inv_q;
   logic [WAY_BITS-1:0] victim_way_q;

   lru_set_update #(.ASSOC(ASSOC)) u_touch (
      .age_i(age_q[bus.touch_index]), .valid_i(valid_q[bus.touch_index]),
      .touch_en_i(1'b1), .touch_way_i(bus.touch_way), .touch_fill_i(bus.touch_fill),
      .inv_en_i(1'b0), .inv_way_i('0),
      .age_o(t_age_d), .valid_o(t_valid_d)
   );

   lru_set_update #(.ASSOC(ASSOC)) u_inv (
      .age_i(age_q[bus.inv_index]), .valid_i(valid_q[bus.inv_index]),
      .touch_en_i(1'b0), .touch_way_i('0), .touch_fill_i(1'b0),
      .inv_en_i(1'b1), .inv_way_i(bus.inv_way),
      .age_o(i_age_d), .valid_o(i_valid_d)
   );

   assign touch_wr = bus.touch_valid && !(bus.inv_valid && (bus.inv_index == bus.touch_index));

`ifdef LRU_WAY_LOCK_EN
   logic victim_none_q;
   assign lock_mask_w     = bus.lock_mask;
   assign bus.victim_none = victim_none_q;
`else
   assign lock_mask_w = '0;
`endif

   // Lookup sees this cycle's update of its own set.
   always_comb begin
      fwd_age   = age_q[bus.victim_index];
      fwd_valid = valid_q[bus.victim_index];
      if (bus.inv_valid && (bus.inv_index == bus.victim_index)) begin
         fwd_age   = i_age_d;
         fwd_valid = i_valid_d;
      end else if (bus.touch_valid && (bus.touch_index == bus.victim_index)) begin
         fwd_age   = t_age_d;
         fwd_valid = t_valid_d;
      end
   end

   always_comb begin
      unlocked  = ~lock_mask_w;
      inv_cand  = unlocked & ~fwd_valid;
      sel_way_d = '0;
      sel_inv_d = 1'b0;
      found     = 1'b0;
      best_age  = '0;
      if (|inv_cand) begin
         sel_way_d = WAY_BITS'(lowest_set(MAX_ASSOC'(inv_cand)));
         sel_inv_d = 1'b1;
      end else begin
         for (int w = 0; w < ASSOC; w++) begin
            if (unlocked[w] && (!found || (fwd_age[w*WAY_BITS +: WAY_BITS] < best_age))) begin
               found     = 1'b1;
               best_age  = fwd_age[w*WAY_BITS +: WAY_BITS];
               sel_way_d = WAY_BITS'(w);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            age_q[s]   <= AGE_RST;
            valid_q[s] <= '0;
         end
         victim_valid_q <= 1'b0;
         victim_way_q   <= '0;
         victim_inv_q   <= 1'b0;
`ifdef LRU_WAY_LOCK_EN
         victim_none_q  <= 1'b0;
`endif
      end else begin
         if (touch_wr) begin
            age_q[bus.touch_index]   <= t_age_d;
            valid_q[bus.touch_index] <= t_valid_d;
         end
         if (bus.inv_valid) begin
            age_q[bus.inv_index]   <= i_age_d;
            valid_q[bus.inv_index] <= i_valid_d;
         end
         victim_valid_q <= bus.victim_req;
         if (bus.victim_req) begin
            victim_way_q  <= sel_way_d;
            victim_inv_q  <= sel_inv_d;
`ifdef LRU_WAY_LOCK_EN
            victim_none_q <= ~|unlocked;
`endif
         end
      end
   end

   assign bus.victim_valid       = victim_valid_q;
   assign bus.victim_way         = victim_way_q;
   assign bus.victim_was_invalid = victim_inv_q;

endmodule

// File: tb/tb_lru_replacer.sv
// Scoreboard bench for lru_replacer (NUM_SETS=128, ASSOC=4): directed touches/invalidates,
// expected victims queued at request time and checked by an independent monitor.
module tb_lru_replacer;

   typedef struct {
      logic [1:0] way;
      logic       inv;
      logic       none;
      string      name;
   } exp_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   exp_t exp_q[$];

   lru_replacer_if #(.NUM_SETS(128), .ASSOC(4)) bus ();

   lru_replacer #(.NUM_SETS(128), .ASSOC(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s got=%0d required=%0d", nm, got, exp);
      end
   endtask

   // Monitor: every victim_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.victim_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_victim got way=%0d inv=%0d required=no_pulse",
                     bus.victim_way, bus.victim_was_invalid);
         end else begin
            exp_t e;
            logic bad;
            e   = exp_q.pop_front();
            bad = (bus.victim_way != e.way) || (bus.victim_was_invalid != e.inv);
`ifdef LRU_WAY_LOCK_EN
            bad = bad || (bus.victim_none != e.none);
`endif
            if (bad) begin
               miscompares++;
               $display("FAIL %s got way=%0d inv=%0d required way=%0d inv=%0d none=%0d",
                        e.name, bus.victim_way, bus.victim_was_invalid, e.way, e.inv, e.none);
            end else begin
               $display("vec %s: way=%0d inv=%0d ok", e.name, bus.victim_way, bus.victim_was_invalid);
            end
         end
      end
   end

   task automatic idle();
      bus.touch_valid  = 1'b0;
      bus.touch_index  = '0;
      bus.touch_way    = '0;
      bus.touch_fill   = 1'b0;
      bus.inv_valid    = 1'b0;
      bus.inv_index    = '0;
      bus.inv_way      = '0;
      bus.victim_req   = 1'b0;
      bus.victim_index = '0;
`ifdef LRU_WAY_LOCK_EN
      bus.lock_mask    = '0;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_touch(input int idx, input int way, input bit fill);
      bus.touch_valid = 1'b1;
      bus.touch_index = 7'(idx);
      bus.touch_way   = 2'(way);
      bus.touch_fill  = fill;
   endtask

   task automatic set_inv(input int idx, input int way);
      bus.inv_valid = 1'b1;
      bus.inv_index = 7'(idx);
      bus.inv_way   = 2'(way);
   endtask

   task automatic set_vreq(input string nm, input int idx, input int way, input bit inv, input bit none);
      exp_t e;
      bus.victim_req   = 1'b1;
      bus.victim_index = 7'(idx);
      e.way  = 2'(way);
      e.inv  = inv;
      e.none = none;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic touch(input int idx, input int way, input bit fill);
      set_touch(idx, way, fill);
      step();
      idle();
   endtask

   task automatic inv(input int idx, input int way);
      set_inv(idx, way);
      step();
      idle();
   endtask

   task automatic vreq(input string nm, input int idx, input int way, input bit inv_exp);
      set_vreq(nm, idx, way, inv_exp, 1'b0);
      step();
      idle();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      idle();
      reset = 1'b0;
      step();
      step();
      chk("reset_valid", int'(bus.victim_valid), 0);
      chk("reset_way", int'(bus.victim_way), 0);
      chk("reset_inv", int'(bus.victim_was_invalid), 0);
      reset = 1'b1;
      step();

      vreq("reset_set5", 5, 0, 1'b1);

      // Set 3: fill ways 0..3 in order -> way0 LRU; touch way0 -> way1 LRU.
      for (int w = 0; w < 4; w++) touch(3, w, 1'b1);
      vreq("fill_order_lru", 3, 0, 1'b0);
      touch(3, 0, 1'b0);
      vreq("touch_promote", 3, 1, 1'b0);

      // Ages {3,2,1,0}; invalidate way0 -> ages {0,3,2,1}, valid 1110.
      for (int w = 3; w >= 0; w--) touch(3, w, 1'b0);
      vreq("ages_3210", 3, 3, 1'b0);
      inv(3, 0);
      vreq("inv_way0", 3, 0, 1'b1);
      touch(3, 0, 1'b1);
      vreq("refill_way0", 3, 3, 1'b0);

      // Set 7: ages w2=0,w0=1,w1=2,w3=3; same-cycle touch of way2 is forwarded.
      touch(7, 2, 1'b1);
      touch(7, 0, 1'b1);
      touch(7, 1, 1'b1);
      touch(7, 3, 1'b1);
      vreq("lru_way2", 7, 2, 1'b0);
      set_touch(7, 2, 1'b0);
      set_vreq("fwd_touch", 7, 0, 1'b0, 1'b0);
      step();
      idle();
      set_touch(7, 2, 1'b1);
      set_inv(7, 2);
      step();
      idle();
      vreq("inv_beats_touch", 7, 2, 1'b1);
      touch(7, 2, 1'b1);
      vreq("refill_way2", 7, 0, 1'b0);

      // Different indices in the same cycle: both applied.
      set_inv(3, 1);
      set_touch(7, 0, 1'b0);
      step();
      idle();
      vreq("split_inv_set3", 3, 1, 1'b1);
      vreq("split_touch_set7", 7, 1, 1'b0);

      // Same-cycle invalidate forwarded to lookup.
      set_inv(7, 3);
      set_vreq("fwd_inv", 7, 3, 1'b1, 1'b0);
      step();
      idle();
      step();
      chk("hold_valid", int'(bus.victim_valid), 0);
      chk("hold_way", int'(bus.victim_way), 3);
      chk("hold_inv", int'(bus.victim_was_invalid), 1);

      // Reset with a request in flight: no pulse, all sets back to reset state.
      bus.victim_req   = 1'b1;
      bus.victim_index = 7'd3;
      reset = 1'b0;
      step();
      idle();
      chk("midreset_valid", int'(bus.victim_valid), 0);
      chk("midreset_way", int'(bus.victim_way), 0);
      reset = 1'b1;
      step();
      chk("post_reset_valid", int'(bus.victim_valid), 0);
      vreq("post_reset_set3", 3, 0, 1'b1);
      vreq("post_reset_set7", 7, 0, 1'b1);
      touch(3, 2, 1'b1);
      vreq("partial_fill", 3, 0, 1'b1);
      touch(3, 0, 1'b1);
      touch(3, 1, 1'b1);
      touch(3, 3, 1'b1);
      vreq("reset_ages_order", 3, 2, 1'b0);

`ifdef LRU_WAY_LOCK_EN
      // Set 3 ages w0=0,w1=1,w3=2,w2=3 after this touch.
      touch(3, 2, 1'b0);
      bus.lock_mask = 4'b0001;
      set_vreq("lock_lru", 3, 1, 1'b0, 1'b0);
      step();
      idle();
      bus.lock_mask = 4'b1111;
      set_vreq("lock_all", 3, 0, 1'b0, 1'b1);
      step();
      idle();
`endif

      step();
      step();
      step();
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lru_replacer.md
# lru_replacer

Parametrised true-LRU replacement engine for the set-associative cache controller. It keeps a per-set age permutation and per-way valid bits, promotes ways on hit/fill, and demotes ways on invalidate. On request it returns a registered victim way, preferring invalid ways. It sits beside the tag array and serves the miss path of the cache FSM.

## Interface
- NUM_SETS, 128, number of sets; power of two, ≥2
- ASSOC, 4, ways per set; power of two, 2..16
- INDEX_BITS, $clog2(NUM_SETS), derived localparam
- WAY_BITS, $clog2(ASSOC), derived localparam; also the width of each age counter
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset
- touch_valid  input  1  hit or fill access this cycle
- touch_index  input  INDEX_BITS  set of the touch
- touch_way  input  WAY_BITS  way made MRU
- touch_fill  input  1  with touch_valid, also sets the way's valid bit
- inv_valid  input  1  invalidate request
- inv_index  input  INDEX_BITS  set to invalidate
- inv_way  input  WAY_BITS  way to invalidate
- victim_req  input  1  victim lookup request
- victim_index  input  INDEX_BITS  set of the lookup
- victim_valid  output  1  one-cycle pulse carrying the result
- victim_way  output  WAY_BITS  selected way
- victim_was_invalid  output  1  selected way was invalid, so no writeback is needed

## Operation
- State per set: age[w], WAY_BITS wide, always a permutation of 0..ASSOC-1 (0 = LRU, ASSOC-1 = MRU), plus valid[w].
- Touch of way w with old age a: every way with age > a decrements by 1; w becomes ASSOC-1. If touch_fill is high, valid[w] becomes 1.
- Invalidate of way w with old age a: every way with age < a increments by 1; w becomes 0; valid[w] becomes 0.
- Touch and invalidate on the same index in the same cycle: the invalidate is applied and the touch is dropped. On different indices, both are applied.
- Victim selection when no lock applies:
  - If any way in the set is invalid, select the lowest-numbered invalid way and set victim_was_invalid=1.
  - Otherwise select the way with age 0 and set victim_was_invalid=0.
- A lookup never modifies state. The cache FSM must issue a touch_fill for the chosen way.
- The lookup sees the post-update state of any same-cycle touch or invalidate on the same index (forwarded through the next-state logic).

## Timing
- Reset while reset=0 at a clk edge:
  - age[s][w]=w and valid=0 for every set.
  - victim_valid=0, victim_way=0, victim_was_invalid=0.
  - Any in-flight request is discarded.
- A touch or invalidate updates state at the edge of the cycle it is asserted; the new state is visible to a lookup issued the next cycle.
- Victim latency is 1: victim_req at edge N gives victim_valid=1 with its result during cycle N+1.
- victim_valid is high for exactly one cycle per request. Back-to-back requests are accepted every cycle; there is no stall and no ready signal.
- victim_way and victim_was_invalid hold their last value when victim_valid=0.

## Configuration
- LRU_WAY_LOCK_EN defined:
  - Adds input lock_mask [ASSOC-1:0] and output victim_none (reset 0).
  - Locked ways are excluded from selection.
  - Among unlocked ways, an invalid way is preferred; otherwise the unlocked way with the lowest age is selected.
  - If all ways are locked: victim_none=1 and victim_way=0 alongside victim_valid.
- LRU_WAY_LOCK_EN undefined: neither port exists and selection follows Operation.

## Structure
- Package lru_pkg holds:
  - the age-vector and valid-vector widths as functions of ASSOC;
  - the reset age encoding (age=w);
  - a helper function that finds the lowest set bit.
- Sub-module lru_set_update: combinational next-state for one set (ages and valid) from the touch and invalidate inputs. It is instantiated once per active port path, and its output feeds both the state registers and the victim forwarding path.

## Test plan
- After reset, ASSOC=4: victim_req on set 5 -> next cycle victim_valid=1, victim_way=0, victim_was_invalid=1.
- Fill ways 0..3 of set 3 in order, then victim_req -> victim_way=0 with victim_was_invalid=0; touch way 0, then victim_req -> victim_way=1.
- Set 3 full with ages {3,2,1,0}, invalidate way 0 -> ages {0,3,2,1} and valid=4'b1110; victim_req -> way 0 with victim_was_invalid=1.
- Same cycle, same index: touch way 2 and victim_req on a full set whose LRU is way 2 -> victim is the way that held age 1, not way 2. Touch and invalidate of way 2 in the same cycle -> way 2 invalid with age 0.
- Assert reset=0 for one cycle mid-sequence while a victim_req is in flight -> victim_valid=0 next cycle and all sets return to the reset state.
- With LRU_WAY_LOCK_EN, lock_mask=4'b0001 on a full set whose LRU is way 0 -> the victim is the way with age 1; lock_mask=4'b1111 -> victim_none=1 and victim_way=0.
